// File: rtl/rs_issue_scheduler_if.sv
// Handshake bundle between the reservation-station heads, the issue scheduler
// and the shared functional units.
interface rs_issue_scheduler_if #(
  parameter int RS_COUNT = 4,
  parameter int FU_COUNT = 2
);
  localparam int SRC_W = $clog2(RS_COUNT);

  logic [RS_COUNT-1:0]               rs_valid;
  logic [RS_COUNT-1:0]               rs_operands_ready;
  logic [RS_COUNT-1:0][FU_COUNT-1:0] rs_fu_mask;
  logic [RS_COUNT-1:0]               rs_ready;
  logic [FU_COUNT-1:0]               fu_issue_valid;
  logic [FU_COUNT-1:0][SRC_W-1:0]    fu_issue_src;
  logic [FU_COUNT-1:0]               fu_done;
  logic [FU_COUNT-1:0]               fu_kill;
  logic                              flush;

  modport master (
    output rs_valid, rs_operands_ready, rs_fu_mask, fu_done, flush,
    input  rs_ready, fu_issue_valid, fu_issue_src, fu_kill
  );

  modport slave (
    input  rs_valid, rs_operands_ready, rs_fu_mask, fu_done, flush,
    output rs_ready, fu_issue_valid, fu_issue_src, fu_kill
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Round-robin issue of reservation-station heads onto shared non-pipelined units.
// Optional AGE_PRIORITY_EN adds per-station wait counters that promote starved stations.
//
// state    | meaning
// IDLE     | unit free, may take an operation this cycle
// BUSY     | operation in flight, result wanted
// DRAIN    | operation in flight after flush, result killed
module rs_issue_scheduler #(
  parameter int RS_COUNT  = 4,
  parameter int FU_COUNT  = 2,
  parameter int AGE_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rs_issue_scheduler_if.slave  bus
);
  localparam int SRC_W = $clog2(RS_COUNT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [FU_COUNT-1:0][1:0]       state_q, state_d;
  logic [FU_COUNT-1:0][SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [FU_COUNT-1:0]            kill_q;
  logic [FU_COUNT-1:0]            grant;
  logic [FU_COUNT-1:0][SRC_W-1:0] grant_src;
  logic [RS_COUNT-1:0]            eligible;
  logic [RS_COUNT-1:0]            taken;
  logic [RS_COUNT-1:0]            age_sat;
  logic [SRC_W-1:0]               sel;
  logic                           found;
  int                             sum;

  assign eligible = bus.rs_valid & bus.rs_operands_ready;

`ifdef AGE_PRIORITY_EN
  logic [RS_COUNT-1:0][AGE_WIDTH-1:0] age_q;

  always_comb begin
    age_sat = '0;
    for (int i = 0; i < RS_COUNT; i++) age_sat[i] = &age_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else begin
      for (int i = 0; i < RS_COUNT; i++) begin
        if (bus.flush || taken[i])
          age_q[i] <= '0;
        else if (eligible[i] && !age_sat[i])
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end
`else
  assign age_sat = '0;
`endif

  // Units allocate in index order; a station claimed by a lower unit is masked for the rest.
  always_comb begin
    taken     = '0;
    grant     = '0;
    grant_src = '0;
    rr_ptr_d  = rr_ptr_q;
    found     = 1'b0;
    sum       = 0;
    sel       = '0;
    for (int j = 0; j < FU_COUNT; j++) begin
      found = 1'b0;
      if (rst_n && !bus.flush && state_q[j] == ST_IDLE) begin
        for (int i = 0; i < RS_COUNT; i++) begin
          if (!found && age_sat[i] && eligible[i] && !taken[i] && bus.rs_fu_mask[i][j]) begin
            found        = 1'b1;
            taken[i]     = 1'b1;
            grant[j]     = 1'b1;
            grant_src[j] = SRC_W'(i);
            rr_ptr_d[j]  = (i == RS_COUNT-1) ? '0 : SRC_W'(i + 1);
          end
        end
        for (int k = 0; k < RS_COUNT; k++) begin
          sum = int'(rr_ptr_q[j]) + k;
          if (sum >= RS_COUNT) sum = sum - RS_COUNT;
          sel = SRC_W'(sum);
          if (!found && eligible[sel] && !taken[sel] && bus.rs_fu_mask[sel][j]) begin
            found        = 1'b1;
            taken[sel]   = 1'b1;
            grant[j]     = 1'b1;
            grant_src[j] = sel;
            rr_ptr_d[j]  = (sum == RS_COUNT-1) ? '0 : SRC_W'(sum + 1);
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    for (int j = 0; j < FU_COUNT; j++) begin
      case (state_q[j])
        ST_IDLE:  if (grant[j]) state_d[j] = ST_BUSY;
        ST_BUSY: begin
          if (bus.fu_done[j])  state_d[j] = ST_IDLE;
          else if (bus.flush)  state_d[j] = ST_DRAIN;
        end
        ST_DRAIN: if (bus.fu_done[j]) state_d[j] = ST_IDLE;
        default:  state_d[j] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      rr_ptr_q <= '0;
      kill_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      for (int j = 0; j < FU_COUNT; j++) kill_q[j] <= (state_d[j] == ST_DRAIN);
    end
  end

  assign bus.rs_ready       = taken;
  assign bus.fu_issue_valid = grant;
  assign bus.fu_issue_src   = grant_src;
  assign bus.fu_kill        = kill_q;
endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Issue scheduler between the reservation stations and the shared non-pipelined functional units. Each cycle it picks operand-ready reservation-station heads and matches them to idle, capable functional units, using round-robin fairness per unit. It pops the winners through the stations' ready handshake and tracks each unit's occupancy until completion. On flush it drains in-flight operations and kills their results.

## Interface
- RS_COUNT, 4, number of requesting reservation stations (one head entry each, ≥2)
- FU_COUNT, 2, number of shared functional units (≥1)
- AGE_WIDTH, 3, width of per-station wait counter (used only with AGE_PRIORITY_EN)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs_valid  in  RS_COUNT  station head entry present
- rs_operands_ready  in  RS_COUNT  head entry has no pending source operands
- rs_fu_mask  in  RS_COUNT×FU_COUNT  units able to execute station i's head entry
- rs_ready  out  RS_COUNT  pop strobe to station i (its ready_in), combinational
- fu_issue_valid  out  FU_COUNT  unit j accepts an operation this cycle, combinational
- fu_issue_src  out  FU_COUNT×$clog2(RS_COUNT)  station index routed to unit j; 0 when not issuing
- fu_done  in  FU_COUNT  one-cycle completion pulse from unit j
- fu_kill  out  FU_COUNT  unit j's in-flight result must be discarded, registered
- flush  in  1  pipeline flush

## Operation
- Per-unit FSM, states IDLE, BUSY, DRAIN:
  - IDLE → BUSY on issue to that unit.
  - BUSY → IDLE on fu_done.
  - BUSY → DRAIN on flush, unless fu_done occurs in the same cycle, which goes to IDLE.
  - DRAIN → IDLE on fu_done.
- fu_kill[j] = 1 exactly while unit j is in DRAIN.
- Eligible station i: rs_valid[i] & rs_operands_ready[i].
- Candidate unit j: state IDLE and flush = 0.
- Allocation is sequential in unit index, 0 first. Unit j takes the first eligible station with rs_fu_mask[i][j] = 1 not already taken by a lower unit. The scan starts at rr_ptr[j] and wraps modulo RS_COUNT.
- At most one station per unit and one unit per station per cycle.
- On issue to station i: rs_ready[i] = 1, fu_issue_valid[j] = 1, fu_issue_src[j] = i.
- rr_ptr[j] updates to (i+1) mod RS_COUNT on issue and holds otherwise. A unit that finds no match leaves its pointer unchanged.
- flush = 1 blocks all issue that cycle: rs_ready = 0 and fu_issue_valid = 0.
- rs_ready is never asserted for an ineligible station.
- fu_done while IDLE is ignored.

## Timing
- Issue decision is combinational in the same cycle. The station pops at the following rising edge, and the unit enters BUSY at that edge.
- The earliest re-issue to the same unit is the cycle after fu_done. IDLE is entered at the fu_done edge, so there is no same-cycle completion-and-issue.
- fu_kill asserts the cycle after flush and deasserts the cycle after the fu_done pulse seen in DRAIN.
- Reset, asynchronous on rst_n low:
  - Every FSM goes to IDLE.
  - rr_ptr = 0 and all age counters = 0.
  - fu_kill = 0.
  - rs_ready, fu_issue_valid and fu_issue_src are forced to 0 while rst_n = 0.
  - Reset mid-operation abandons BUSY/DRAIN units with no kill pulse.
- Round-robin wraps from RS_COUNT−1 to 0.
- All stations eligible and all units idle: each unit issues, up to min(RS_COUNT, FU_COUNT) grants.

## Configuration
- Macro AGE_PRIORITY_EN.
- Defined: each station keeps a wait counter with AGE_WIDTH bits.
  - Increments, saturating, each cycle the station is eligible but not granted.
  - Clears on grant or flush.
  - Saturated (all-ones) stations are scanned first, in index order, ahead of the round-robin order for every unit. Among saturated stations, the lowest index wins.
- Undefined: pure round-robin as above, and no counters are instantiated.

## Test plan
- Reset: hold rst_n = 0 with all inputs active → rs_ready = 0, fu_issue_valid = 0, fu_kill = 0. Release → first grant goes to station 0.
- RS_COUNT = 4, FU_COUNT = 1, all stations eligible and mask all-ones, fu_done two cycles after each issue → grants in order 0, 1, 2, 3, 0, with one issue every 3 cycles.
- Stations 0 and 1 eligible, station 0 mask = 01, station 1 mask = 11, both units idle → unit 0 takes station 0 and unit 1 takes station 1 in the same cycle. Neither station gets a double grant.
- Station eligible but rs_operands_ready = 0 → no rs_ready. Raise operands ready → grant the same cycle.
- Unit 0 BUSY, flush pulse → no issue that cycle; fu_kill[0] = 1 next cycle. fu_done three cycles later → fu_kill[0] = 0 and the unit issues again next cycle.
- With AGE_PRIORITY_EN, AGE_WIDTH = 2: station 3 is starved by a mask-only-matches-later pattern for 3 cycles → the next cycle it is granted ahead of rr_ptr order. Without the macro → round-robin order is unchanged.
